mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- RAM-side responder for the MEM-stage load/store request interface and the IF-stage instruction fetch.
- Arbitrates between the two requesters and serialises each access into byte-wide transfers on a synchronous 8-bit RAM port.
- Returns a one-cycle done pulse and the raw assembled read data.
- Sits between the core pipeline (IF/MEM stages) and the external RAM/IO bus.

Parameters:
ADDR_W, 32, width of ram_a_o; low ADDR_W bits of the request address

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
if_req_i  input  1  instruction fetch request (always 4 bytes)
if_addr_i  input  32  fetch address
if_done_o  output  1  one-cycle pulse: fetch complete
if_data_o  output  32  fetched word; valid while if_done_o=1, held until next fetch completes
mem_r_req_i  input  1  load request
mem_w_req_i  input  1  store request
mem_addr_i  input  32  load/store byte address
mem_w_data_i  input  32  store data; byte k is bits [8k+7:8k]
mem_state_i  input  2  size: 00=byte, 01=half, 11=word, 10=treated as word
mem_done_o  output  1  one-cycle pulse: load/store complete
mem_r_data_o  output  32  load data, zero-filled above size; held until next load completes
ram_din_i  input  8  RAM read byte, one cycle after ram_a_o
ram_dout_o  output  8  RAM write byte
ram_a_o  output  ADDR_W  RAM byte address
ram_wr_o  output  1  1=write ram_dout_o to ram_a_o at this edge

Behaviour:
- All outputs are registered. Reset (rst=1 at posedge):
  - state=IDLE.
  - if_done_o, mem_done_o, ram_wr_o, ram_a_o, ram_dout_o, if_data_o, mem_r_data_o all 0.
- Reset overrides any in-flight access.
  - No done pulse is issued.
  - Bytes already written stay written.
- Byte count n: 1, 2 or 4 from mem_state_i. Fetch n=4. Little-endian: byte k at addr+k.
- States:
  - IDLE: samples requests.
  - READ: issues read addresses and captures returned bytes.
  - WRITE: writes one byte per cycle.
  - DONE: done pulse visible; always returns to IDLE next cycle, with no request sampling in DONE.
- Arbitration in IDLE at cycle T, in priority order:
  - mem_w_req_i
  - mem_r_req_i
  - if_req_i
  - Requests arriving outside IDLE wait. Requesters hold the request until their done pulse.
- Read, request sampled at cycle T:
  - ram_a_o = addr+k during cycle T+1+k, for k=0..n-1.
  - Byte k is captured from ram_din_i at the end of cycle T+2+k.
  - The last capture sets done and data together, so done is high in cycle T+n+2: byte → T+3, half → T+4, word → T+6.
  - Unused upper bytes of mem_r_data_o are 0. Sign extension is the requester's job.
- Write, request sampled at cycle T:
  - ram_wr_o=1, ram_a_o=addr+k, ram_dout_o=byte k during cycle T+1+k.
  - ram_wr_o=0 afterwards.
  - mem_done_o high in cycle T+n+1: byte → T+2, half → T+3, word → T+5.
- Only the served requester's done pulses. The other done stays 0.
- Address arithmetic is modulo 2^ADDR_W (wrap at top). No alignment checks.
- ram_wr_o is 0 in IDLE, READ and DONE.

Optional Feature:
- MEM_CTRL_IO_FULL_EN defined:
  - Adds input io_buffer_full_i (1 bit).
  - In IDLE, a store with mem_addr_i[17:16]=2'b11 is not accepted while io_buffer_full_i=1. The store is held pending.
  - A lower-priority if_req_i may be served in that cycle.
  - I/O loads are unaffected.
- Undefined: the port is absent and stores are never blocked.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random request inputs -> all outputs 0, no done pulse, state IDLE.
- Word load: RAM[0x100..0x103]=11,22,33,44, LW 0x100 sampled at T -> ram_a_o 0x100..0x103 in T+1..T+4; mem_done_o=1 only in T+6 with mem_r_data_o=0x44332211.
- Half store: SH 0x200 with data 0xABCD1234 at T -> writes 0x34@0x200 (T+1), 0x12@0x201 (T+2); RAM[0x202] unchanged; mem_done_o only in T+3.
- Arbitration: if_req 0x0 and LB 0x10 (RAM=0x80) both at T -> mem_done_o at T+3 with 0x00000080; fetch sampled T+4, if_done_o only at T+10; if_done_o never pulses at T+3.
- Reset mid-access: LW started at T, rst=1 at T+3 -> IDLE at T+4, no done pulse, ram_wr_o=0; new LB accepted normally afterwards.
- With MEM_CTRL_IO_FULL_EN: io_buffer_full_i=1, SB 0x30000 data 0x41 -> ram_wr_o stays 0; drop full in cycle X -> ram_wr_o=1 with dout 0x41 in X+1, mem_done_o in X+2.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Core-side request/response and byte-wide RAM signals for mem_ctrl.
// io_buffer_full_i exists only when MEM_CTRL_IO_FULL_EN is defined.
interface mem_ctrl_if #(parameter int ADDR_W = 32);
    logic              if_req_i;
    logic [31:0]       if_addr_i;
    logic              if_done_o;
    logic [31:0]       if_data_o;
    logic              mem_r_req_i;
    logic              mem_w_req_i;
    logic [31:0]       mem_addr_i;
    logic [31:0]       mem_w_data_i;
    logic [1:0]        mem_state_i;
    logic              mem_done_o;
    logic [31:0]       mem_r_data_o;
    logic [7:0]        ram_din_i;
    logic [7:0]        ram_dout_o;
    logic [ADDR_W-1:0] ram_a_o;
    logic              ram_wr_o;
`ifdef MEM_CTRL_IO_FULL_EN
    logic              io_buffer_full_i;

    modport master (
        output if_req_i, if_addr_i, mem_r_req_i, mem_w_req_i, mem_addr_i,
               mem_w_data_i, mem_state_i, ram_din_i, io_buffer_full_i,
        input  if_done_o, if_data_o, mem_done_o, mem_r_data_o,
               ram_dout_o, ram_a_o, ram_wr_o
    );
    modport slave (
        input  if_req_i, if_addr_i, mem_r_req_i, mem_w_req_i, mem_addr_i,
               mem_w_data_i, mem_state_i, ram_din_i, io_buffer_full_i,
        output if_done_o, if_data_o, mem_done_o, mem_r_data_o,
               ram_dout_o, ram_a_o, ram_wr_o
    );
`else
    modport master (
        output if_req_i, if_addr_i, mem_r_req_i, mem_w_req_i, mem_addr_i,
               mem_w_data_i, mem_state_i, ram_din_i,
        input  if_done_o, if_data_o, mem_done_o, mem_r_data_o,
               ram_dout_o, ram_a_o, ram_wr_o
    );
    modport slave (
        input  if_req_i, if_addr_i, mem_r_req_i, mem_w_req_i, mem_addr_i,
               mem_w_data_i, mem_state_i, ram_din_i,
        output if_done_o, if_data_o, mem_done_o, mem_r_data_o,
               ram_dout_o, ram_a_o, ram_wr_o
    );
`endif
endinterface

// File: rtl/mem_ctrl.sv
// Purpose: arbitrates IF fetches and MEM loads/stores onto a byte-wide synchronous RAM (MEM_CTRL_IO_FULL_EN adds I/O store blocking).
// Latency: read done at T+n+2, write done at T+n+1 after the IDLE sample cycle T (n = 1/2/4 bytes).
// Backpressure: requests are only sampled in IDLE; requesters hold until their done pulse.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic              fetch_q, fetch_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdat_q, wdat_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;

    logic              store_ok;
    logic [1:0]        cap_idx;
    logic [1:0]        nxt_idx;
    logic [ADDR_W-1:0] nxt_addr;

    function automatic logic [2:0] size_len(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Stores to the I/O window wait while the I/O buffer is full; loads never do.
`ifdef MEM_CTRL_IO_FULL_EN
    assign store_ok = bus.mem_w_req_i &&
                      !(bus.io_buffer_full_i && (bus.mem_addr_i[17:16] == 2'b11));
`else
    assign store_ok = bus.mem_w_req_i;
`endif

    // cnt_q counts cycles spent in READ/WRITE; reads capture one cycle behind the address.
    assign cap_idx  = cnt_q[1:0] - 2'd1;
    assign nxt_idx  = cnt_q[1:0] + 2'd1;
    assign nxt_addr = base_q + ADDR_W'(cnt_q + 3'd1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        fetch_d    = fetch_q;
        base_d     = base_q;
        wdat_d     = wdat_q;
        rbuf_d     = rbuf_q;
        if_done_d  = 1'b0;
        mem_done_d = 1'b0;
        if_data_d  = if_data_q;
        mem_data_d = mem_data_q;
        ram_a_d    = ram_a_q;
        ram_dout_d = ram_dout_q;
        ram_wr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d  = 3'd0;
                rbuf_d = 32'd0;
                if (store_ok) begin
                    state_d    = WRITE;
                    fetch_d    = 1'b0;
                    len_d      = size_len(bus.mem_state_i);
                    base_d     = bus.mem_addr_i[ADDR_W-1:0];
                    wdat_d     = bus.mem_w_data_i;
                    ram_wr_d   = 1'b1;
                    ram_a_d    = bus.mem_addr_i[ADDR_W-1:0];
                    ram_dout_d = bus.mem_w_data_i[7:0];
                end else if (bus.mem_r_req_i) begin
                    state_d = READ;
                    fetch_d = 1'b0;
                    len_d   = size_len(bus.mem_state_i);
                    base_d  = bus.mem_addr_i[ADDR_W-1:0];
                    ram_a_d = bus.mem_addr_i[ADDR_W-1:0];
                end else if (bus.if_req_i) begin
                    state_d = READ;
                    fetch_d = 1'b1;
                    len_d   = 3'd4;
                    base_d  = bus.if_addr_i[ADDR_W-1:0];
                    ram_a_d = bus.if_addr_i[ADDR_W-1:0];
                end
            end
            READ: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q != 3'd0) begin
                    rbuf_d[{cap_idx, 3'b000} +: 8] = bus.ram_din_i;
                end
                if ((cnt_q + 3'd1) < len_q) begin
                    ram_a_d = nxt_addr;
                end
                if (cnt_q == len_q) begin
                    state_d = DONE;
                    if (fetch_q) begin
                        if_done_d = 1'b1;
                        if_data_d = rbuf_d;
                    end else begin
                        mem_done_d = 1'b1;
                        mem_data_d = rbuf_d;
                    end
                end
            end
            WRITE: begin
                if ((cnt_q + 3'd1) < len_q) begin
                    cnt_d      = cnt_q + 3'd1;
                    ram_wr_d   = 1'b1;
                    ram_a_d    = nxt_addr;
                    ram_dout_d = wdat_q[{nxt_idx, 3'b000} +: 8];
                end else begin
                    state_d    = DONE;
                    mem_done_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            len_q      <= 3'd0;
            fetch_q    <= 1'b0;
            base_q     <= '0;
            wdat_q     <= 32'd0;
            rbuf_q     <= 32'd0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            if_data_q  <= 32'd0;
            mem_data_q <= 32'd0;
            ram_a_q    <= '0;
            ram_dout_q <= 8'd0;
            ram_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            fetch_q    <= fetch_d;
            base_q     <= base_d;
            wdat_q     <= wdat_d;
            rbuf_q     <= rbuf_d;
            if_done_q  <= if_done_d;
            mem_done_q <= mem_done_d;
            if_data_q  <= if_data_d;
            mem_data_q <= mem_data_d;
            ram_a_q    <= ram_a_d;
            ram_dout_q <= ram_dout_d;
            ram_wr_q   <= ram_wr_d;
        end
    end

    assign bus.if_done_o    = if_done_q;
    assign bus.if_data_o    = if_data_q;
    assign bus.mem_done_o   = mem_done_q;
    assign bus.mem_r_data_o = mem_data_q;
    assign bus.ram_a_o      = ram_a_q;
    assign bus.ram_dout_o   = ram_dout_q;
    assign bus.ram_wr_o     = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: synchronous RAM model, per-cycle expectation tables filled from
// transaction-level timing rules, and one compare process checking every cycle.
module tb_mem_ctrl;
    localparam int N = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(32)) bus ();
    mem_ctrl #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    bit [7:0] ram [0:262143];
    bit [7:0] mdl [0:262143];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        bus.ram_din_i <= ram[bus.ram_a_o[17:0]];
        if (bus.ram_wr_o === 1'b1) ram[bus.ram_a_o[17:0]] <= bus.ram_dout_o;
    end

    bit          exp_wr [N];
    bit          exp_av [N];
    bit          exp_md [N];
    bit          exp_id [N];
    bit          exp_ml [N];
    logic [31:0] exp_a  [N];
    logic [31:0] exp_dat[N];
    logic [7:0]  exp_do [N];
    int          free_at;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic int size_n(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    task automatic plan_read(input int t, input bit fetch, input logic [31:0] a,
                             input int n, output logic [31:0] d);
        logic [31:0] ak;
        d = 32'd0;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            exp_av[t+1+k] = 1'b1;
            exp_a[t+1+k]  = ak;
            d = d | ({24'd0, mdl[ak[17:0]]} << (8 * k));
        end
        if (fetch) exp_id[t+n+2] = 1'b1;
        else begin
            exp_md[t+n+2] = 1'b1;
            exp_ml[t+n+2] = 1'b1;
        end
        exp_dat[t+n+2] = d;
        free_at = t + n + 3;
    endtask

    task automatic plan_write(input int t, input logic [31:0] a, input int n,
                              input logic [31:0] wd);
        logic [31:0] ak;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            exp_wr[t+1+k] = 1'b1;
            exp_av[t+1+k] = 1'b1;
            exp_a[t+1+k]  = ak;
            exp_do[t+1+k] = wd[8*k +: 8];
            mdl[ak[17:0]] = wd[8*k +: 8];
        end
        exp_md[t+n+1] = 1'b1;
        free_at = t + n + 2;
    endtask

    task automatic cancel_from(input int c);
        for (int i = c; i < N; i++) begin
            exp_wr[i] = 1'b0; exp_av[i] = 1'b0; exp_md[i] = 1'b0;
            exp_id[i] = 1'b0; exp_ml[i] = 1'b0;
        end
    endtask

    // Compare process: held read data follows the model through done pulses and resets.
    bit          chk_en = 1'b0;
    bit          rst_edge;
    logic [31:0] m_mdata = 32'd0;
    logic [31:0] m_idata = 32'd0;
    always @(posedge clk) rst_edge <= rst;
    always @(negedge clk) begin
        if (chk_en && cyc < N) begin
            if (rst_edge) begin
                m_mdata = 32'd0;
                m_idata = 32'd0;
            end
            chk("ram_wr", {31'd0, bus.ram_wr_o}, {31'd0, exp_wr[cyc]});
            chk("mem_done", {31'd0, bus.mem_done_o}, {31'd0, exp_md[cyc]});
            chk("if_done", {31'd0, bus.if_done_o}, {31'd0, exp_id[cyc]});
            if (exp_av[cyc]) chk("ram_a", bus.ram_a_o, exp_a[cyc]);
            if (exp_wr[cyc]) chk("ram_dout", {24'd0, bus.ram_dout_o}, {24'd0, exp_do[cyc]});
            if (exp_ml[cyc]) m_mdata = exp_dat[cyc];
            if (exp_id[cyc]) m_idata = exp_dat[cyc];
            chk("mem_r_data", bus.mem_r_data_o, m_mdata);
            chk("if_data", bus.if_data_o, m_idata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_free();
        while (cyc < free_at) tick();
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, output logic [31:0] d);
        wait_free();
        bus.mem_r_req_i = 1'b1;
        bus.mem_addr_i  = a;
        bus.mem_state_i = sz;
        plan_read(cyc, 1'b0, a, size_n(sz), d);
        wait_free();
        bus.mem_r_req_i = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        wait_free();
        bus.mem_w_req_i  = 1'b1;
        bus.mem_addr_i   = a;
        bus.mem_state_i  = sz;
        bus.mem_w_data_i = wd;
        plan_write(cyc, a, size_n(sz), wd);
        wait_free();
        bus.mem_w_req_i = 1'b0;
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] v);
        ram[a[17:0]] = v;
        mdl[a[17:0]] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int t;

        preload(32'h100, 8'h11); preload(32'h101, 8'h22);
        preload(32'h102, 8'h33); preload(32'h103, 8'h44);
        preload(32'h010, 8'h80);
        preload(32'h200, 8'hA0); preload(32'h201, 8'hA1);
        preload(32'h202, 8'hA2); preload(32'h203, 8'hA3);
        preload(32'hFFFF_FFFE, 8'h5A); preload(32'hFFFF_FFFF, 8'h6B);
        preload(32'h0, 8'h7C); preload(32'h1, 8'h8D);

        rst              = 1'b1;
        bus.if_req_i     = 1'($urandom_range(0, 1));
        bus.if_addr_i    = $urandom;
        bus.mem_r_req_i  = 1'($urandom_range(0, 1));
        bus.mem_w_req_i  = 1'($urandom_range(0, 1));
        bus.mem_addr_i   = $urandom;
        bus.mem_w_data_i = $urandom;
        bus.mem_state_i  = 2'($urandom_range(0, 3));
`ifdef MEM_CTRL_IO_FULL_EN
        bus.io_buffer_full_i = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_done", {31'd0, bus.if_done_o}, 32'd0);
        chk("rst_mem_done", {31'd0, bus.mem_done_o}, 32'd0);
        chk("rst_ram_wr", {31'd0, bus.ram_wr_o}, 32'd0);
        chk("rst_ram_a", bus.ram_a_o, 32'd0);
        chk("rst_ram_dout", {24'd0, bus.ram_dout_o}, 32'd0);
        chk("rst_if_data", bus.if_data_o, 32'd0);
        chk("rst_mem_data", bus.mem_r_data_o, 32'd0);

        rst             = 1'b0;
        bus.if_req_i    = 1'b0;
        bus.mem_r_req_i = 1'b0;
        bus.mem_w_req_i = 1'b0;
        chk_en          = 1'b1;
        free_at         = cyc;

        // Word load
        do_load(32'h100, 2'b11, d);
        chk("lw_model", d, 32'h4433_2211);
        chk("lw_data_held", bus.mem_r_data_o, 32'h4433_2211);

        // Half store; the third byte must stay untouched
        do_store(32'h200, 2'b01, 32'hABCD_1234);
        chk("sh_byte0", {24'd0, ram[18'h200]}, 32'h34);
        chk("sh_byte1", {24'd0, ram[18'h201]}, 32'h12);
        chk("sh_byte2_kept", {24'd0, ram[18'h202]}, 32'hA2);

        // Fetch and byte load together: the load wins, fetch follows after DONE
        wait_free();
        t = cyc;
        bus.if_req_i    = 1'b1;
        bus.if_addr_i   = 32'h0;
        bus.mem_r_req_i = 1'b1;
        bus.mem_addr_i  = 32'h10;
        bus.mem_state_i = 2'b00;
        plan_read(t, 1'b0, 32'h10, 1, d);
        chk("lb_model", d, 32'h80);
        wait_free();
        bus.mem_r_req_i = 1'b0;
        chk("arb_fetch_slot", cyc, t + 4);
        chk("arb_lb_data", bus.mem_r_data_o, 32'h80);
        plan_read(cyc, 1'b1, 32'h0, 4, d);
        chk("fetch_model", d, 32'h0000_8D7C);
        wait_free();
        bus.if_req_i = 1'b0;
        chk("fetch_data_held", bus.if_data_o, 32'h0000_8D7C);

        // Address wrap at the top of the space
        do_load(32'hFFFF_FFFE, 2'b11, d);
        chk("wrap_model", d, 32'h8D7C_6B5A);

        // Size 2'b10 behaves as a word
        do_store(32'h300, 2'b10, 32'hDEAD_BEEF);
        do_load(32'h300, 2'b11, d);
        chk("sw10_readback", d, 32'hDEAD_BEEF);
        do_load(32'h303, 2'b00, d);
        chk("lb_zero_fill", bus.mem_r_data_o, 32'h0000_00DE);

        // Reset in the middle of a word load
        wait_free();
        t = cyc;
        bus.mem_r_req_i = 1'b1;
        bus.mem_addr_i  = 32'h100;
        bus.mem_state_i = 2'b11;
        plan_read(t, 1'b0, 32'h100, 4, d);
        while (cyc < t + 3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_r_req_i = 1'b0;
        cancel_from(cyc);
        free_at = cyc;
        chk("midrst_ram_a", bus.ram_a_o, 32'd0);
        chk("midrst_data", bus.mem_r_data_o, 32'd0);
        do_load(32'h10, 2'b00, d);
        chk("post_rst_lb", bus.mem_r_data_o, 32'h80);

`ifdef MEM_CTRL_IO_FULL_EN
        // I/O store held while the buffer is full
        wait_free();
        bus.io_buffer_full_i = 1'b1;
        bus.mem_w_req_i      = 1'b1;
        bus.mem_addr_i       = 32'h0003_0000;
        bus.mem_state_i      = 2'b00;
        bus.mem_w_data_i     = 32'h41;
        repeat (4) tick();
        bus.io_buffer_full_i = 1'b0;
        plan_write(cyc, 32'h0003_0000, 1, 32'h41);
        wait_free();
        bus.mem_w_req_i = 1'b0;
        chk("io_store", {24'd0, ram[18'h30000]}, 32'h41);
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
